filter_seq_ctrl: RTL
====================

Name: filter_seq_ctrl

Overview:
- Sequencer for one biquad IIR channel built around filter_mem_block, the 5-entry history memory.
- filter_mem_block holds x[n], x[n-1], x[n-2], y[n-1] and y[n-2], with a registered output selected by dir.
- Per input sample, this block performs four steps:
  - shifts the new x into the memory;
  - walks dir 0..4, multiply-accumulating each tap against its coefficient;
  - computes and saturates y, then writes it back via y_enable;
  - presents y on a valid/ready output.
- Also owns a double-buffered coefficient bank with a commit interface.

Parameters:
- DATA_W, 32, sample width; must match filter_mem_block.
- COEF_W, 18, signed coefficient width, Q2.16.
- FRAC, 16, coefficient fractional bits.
- ACC_W, 56, signed accumulator width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- x_enable  out  1  to filter_mem_block: shift x history.
- y_enable  out  1  to filter_mem_block: shift y history.
- dir  out  3  to filter_mem_block: tap select.
- mem_x  out  DATA_W  to filter_mem_block x.
- mem_y  out  DATA_W  to filter_mem_block y.
- mem_out  in  DATA_W  from filter_mem_block out; registered, 1-cycle latency after dir.
- coef_we  in  1  write shadow coefficient.
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored.
- coef_wdata  in  COEF_W  signed Q2.16 coefficient.
- coef_commit  in  1  request shadow-to-active copy.
- commit_pending  out  1  commit requested, not yet applied.
- out_valid  out  1  filtered sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  filtered sample y[n].
- sat_sticky  out  1  saturation has occurred since last clear.
- sat_clear  in  1  clears sat_sticky.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0, except in_ready=1 once reset is released.
  - Accumulator is 0.
  - Active and shadow banks are set to passthrough: b0=0x10000, all others 0.
  - filter_mem_block contents are outside this block's control.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, OUT.
- Cycle 0, IDLE:
  - in_ready=1.
  - On in_valid: x_enable=1 combinationally and mem_x=in_data, accumulator cleared, k=0, go to ISSUE.
- Cycles 1-5, ISSUE:
  - dir=k, k increments 0..4, in_ready=0.
  - After k=4, go to DRAIN.
- Accumulate (cycles 2-6):
  - mem_out holds tap k-1; a registered tap index tracks it.
  - Taps 0..2: acc += mem_out*b[k].
  - Taps 3..4: acc -= mem_out*a[k-3].
  - Product is sign-extended to ACC_W.
- Cycle 6, DRAIN: last accumulate, then go to WRITE.
- Cycle 7, WRITE:
  - ys = acc >>> FRAC (arithmetic shift, floor).
  - If ys > 2^31-1 or ys < -2^31, clamp and set sat_sticky.
  - y_enable=1 with mem_y = clamped y; out_data <= y; go to OUT.
- Cycle 8+, OUT:
  - out_valid=1; out_data stable until out_ready.
  - On out_ready, go to IDLE.
- Throughput: one sample per 9 cycles minimum. x_enable and y_enable are never asserted in the same cycle.
- dir holds its last value outside ISSUE.
- Coefficients:
  - coef_we writes the shadow bank any cycle.
  - coef_commit sets commit_pending.
  - Active bank copies from shadow only in an IDLE cycle with no accept; commit_pending then clears.
  - A sample in flight always uses one consistent bank.
  - A commit and an accept in the same IDLE cycle: accept proceeds with the old bank; commit applies on the next idle cycle.
  - coef_we with the same address in the commit cycle: the new data lands in shadow only.
- sat_clear has priority over a same-cycle saturation set.
- Reset mid-operation: immediate return to IDLE. No further x_enable/y_enable pulses; out_valid drops.

Decomposition:
- Package filter_pkg:
  - state enum;
  - tap index constants B0..A2;
  - passthrough coefficient constant;
  - saturation limits.
- One natural sub-module: filter_mac, containing the multiplier, accumulator, shift and saturation, with clear/acc/sub controls.
- The FSM and coefficient bank stay in top.

Test Plan:
- Passthrough after reset: in_data=100 → out_data=100 with out_valid at cycle 8. Check exactly one x_enable and one y_enable pulse, dir sequence 0,1,2,3,4.
- Gain: shadow b0=0x08000, commit while idle, then 100 → 50; then -7 → -4 (floor).
- Recursion: b0=0x10000, a1=-0x08000; impulse 1000 then zeros → 1000, 500, 250, 125.
- Saturation: b0=b1=b2=0x1FFFF; three samples of 0x7FFFFFFF → third output 0x7FFFFFFF and sat_sticky=1. Then sat_clear → 0.
- Backpressure and commit deferral: out_ready low for 10 cycles. Check out_data stable, in_ready=0, and coef_commit held pending (commit_pending=1) until IDLE.
- Reset in ISSUE at cycle 3: outputs go to 0 immediately; no y_enable; next sample processes normally with reset coefficients.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and constants for the biquad sequencer: FSM states, tap indices,
// the passthrough coefficient and the output saturation limits.
package filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int COEF_W_DEF = 18;
  localparam int FRAC_DEF   = 16;
  localparam int ACC_W_DEF  = 56;
  localparam int NTAPS      = 5;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  // Unity gain in Q2.16
  localparam logic signed [COEF_W_DEF-1:0] COEF_PASS = 18'sh10000;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = 32'sh7FFFFFFF;
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = 32'sh80000000;

endpackage

// File: rtl/filter_mac.sv
// Multiply-accumulate datapath: signed tap*coef products summed or subtracted
// into a wide accumulator, then scaled down by FRAC and clamped to the sample range.
module filter_mac
  import filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_i,
  input  logic                     acc_i,
  input  logic                     sub_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int YS_W   = ACC_W - FRAC;
  localparam logic signed [YS_W-1:0] YS_HI = YS_W'(SAT_MAX);
  localparam logic signed [YS_W-1:0] YS_LO = YS_W'(SAT_MIN);

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [YS_W-1:0]   ys_s;

  // Product, accumulator next value, floor-scaled result and clamp
  always_comb begin
    prod_s     = PROD_W'(sample_i) * PROD_W'(coef_i);
    prod_ext_s = ACC_W'(prod_s);
    acc_d      = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_i) begin
      acc_d = sub_i ? (acc_q - prod_ext_s) : (acc_q + prod_ext_s);
    end else begin
      acc_d = acc_q;
    end
    ys_s  = YS_W'(acc_q >>> FRAC);
    sat_o = 1'b0;
    y_o   = ys_s[DATA_W-1:0];
    if (ys_s > YS_HI) begin
      y_o   = SAT_MAX;
      sat_o = 1'b1;
    end else if (ys_s < YS_LO) begin
      y_o   = SAT_MIN;
      sat_o = 1'b1;
    end else begin
      y_o   = ys_s[DATA_W-1:0];
      sat_o = 1'b0;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/filter_seq_ctrl.sv
// Biquad sequencer: drives the external 5-entry history memory, walks the taps
// through filter_mac and hands y[n] out on valid/ready; owns the coefficient banks.
module filter_seq_ctrl
  import filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     x_enable,
  output logic                     y_enable,
  output logic [2:0]               dir,
  output logic [DATA_W-1:0]        mem_x,
  output logic [DATA_W-1:0]        mem_y,
  input  logic signed [DATA_W-1:0] mem_out,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  output logic                     commit_pending,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     sat_sticky,
  input  logic                     sat_clear
);

  state_e                    state_q;
  logic [2:0]                dir_q;
  logic [2:0]                tap_q;
  logic                      tap_vld_q;
  logic                      in_ready_q;
  logic                      y_en_q;
  logic                      out_valid_q;
  logic [DATA_W-1:0]         out_data_q;
  logic                      pend_q;
  logic                      sat_q;
  logic signed [COEF_W-1:0]  act_q [NTAPS];
  logic signed [COEF_W-1:0]  shd_q [NTAPS];

  logic                      accept_s;
  logic                      apply_s;
  logic                      sub_s;
  logic signed [COEF_W-1:0]  coef_s;
  logic signed [DATA_W-1:0]  mac_y_s;
  logic                      mac_sat_s;

  // Accept and bank-apply are mutually exclusive, so an in-flight sample never sees a bank swap
  always_comb begin
    accept_s = (state_q == ST_IDLE) && in_ready_q && in_valid;
    apply_s  = (state_q == ST_IDLE) && !accept_s && pend_q;
    sub_s    = (tap_q == TAP_A1) || (tap_q == TAP_A2);
    case (tap_q)
      TAP_B0:  coef_s = act_q[0];
      TAP_B1:  coef_s = act_q[1];
      TAP_B2:  coef_s = act_q[2];
      TAP_A1:  coef_s = act_q[3];
      TAP_A2:  coef_s = act_q[4];
      default: coef_s = '0;
    endcase
  end

  assign x_enable       = accept_s;
  assign mem_x          = accept_s ? in_data : '0;
  assign y_enable       = y_en_q;
  assign mem_y          = y_en_q ? mac_y_s : '0;
  assign dir            = dir_q;
  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign commit_pending = pend_q;
  assign sat_sticky     = sat_q;

  filter_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (accept_s),
    .acc_i   (tap_vld_q),
    .sub_i   (sub_s),
    .sample_i(mem_out),
    .coef_i  (coef_s),
    .y_o     (mac_y_s),
    .sat_o   (mac_sat_s)
  );

  // Sequencer FSM; mem_out lags dir by one cycle, so tap_q/tap_vld_q trail dir_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= 3'd0;
      tap_q       <= 3'd0;
      tap_vld_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      y_en_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tap_q     <= dir_q;
      tap_vld_q <= (state_q == ST_ISSUE);
      y_en_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_s) begin
            dir_q      <= TAP_B0;
            in_ready_q <= 1'b0;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dir_q == TAP_A2) begin
            state_q <= ST_DRAIN;
          end else begin
            dir_q <= dir_q + 3'd1;
          end
        end
        ST_DRAIN: begin
          y_en_q  <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          out_data_q  <= mac_y_s;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Shadow/active coefficient banks and the pending-commit flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        act_q[i] <= (i == 0) ? COEF_W'(COEF_PASS) : '0;
        shd_q[i] <= (i == 0) ? COEF_W'(COEF_PASS) : '0;
      end
      pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (coef_we && (coef_addr == 3'(i))) begin
          shd_q[i] <= coef_wdata;
        end
        if (apply_s) begin
          act_q[i] <= shd_q[i];
        end
      end
      pend_q <= coef_commit || (pend_q && !apply_s);
    end
  end

  // Sticky saturation flag; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (sat_clear) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_q || (y_en_q && mac_sat_s);
    end
  end

endmodule
